// File: rtl/mpc_qp_admm_mvmult_row_mac.sv
// rtl/mpc_qp_admm_mvmult_row_mac.sv - One-row fixed-point dot product engine for the ADMM QP solver
module mpc_qp_admm_mvmult_row_mac #(
  parameter int DataWidth    = 18,
  parameter int FracBits     = 16,
  parameter int AddressWidth = 5,
  parameter int RowLength    = 24,
  parameter int AccWidth     = 41
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [AddressWidth-1:0] h_address0_o,
  output logic                    h_ce0_o,
  input  logic [DataWidth-1:0]    h_q0_i,
  output logic [AddressWidth-1:0] x_address0_o,
  output logic                    x_ce0_o,
  input  logic [DataWidth-1:0]    x_q0_i,
  output logic [DataWidth-1:0]    y_o,
  output logic                    sat_o
);

  localparam int ProdWidth = 2 * DataWidth;
  localparam logic [AddressWidth-1:0] LastIdx = AddressWidth'(RowLength - 1);
  localparam logic signed [AccWidth-1:0] RoundConst = AccWidth'(1 <<< (FracBits - 1));
  localparam logic signed [AccWidth-1:0] MaxPos = AccWidth'((1 <<< (DataWidth - 1)) - 1);
  localparam logic signed [AccWidth-1:0] MinNeg = AccWidth'(-(1 <<< (DataWidth - 1)));

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                         state_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           ce_q;
  logic                           sat_q;
  logic [DataWidth-1:0]           y_q;
  logic [AddressWidth-1:0]        addr_q;

  logic                           rd_valid_q;
  logic                           prod_valid_q;
  logic signed [ProdWidth-1:0]    prod_q;
  logic signed [AccWidth-1:0]     acc_q;

  logic signed [ProdWidth-1:0]    h_ext;
  logic signed [ProdWidth-1:0]    x_ext;
  logic signed [AccWidth-1:0]     round_sum;
  logic signed [AccWidth-1:0]     r_sh;
  logic [DataWidth-1:0]           y_d;
  logic                           sat_d;
  logic                           accept;

  assign accept = (state_q == IDLE) && start_i;

  assign h_ext = {{DataWidth{h_q0_i[DataWidth-1]}}, h_q0_i};
  assign x_ext = {{DataWidth{x_q0_i[DataWidth-1]}}, x_q0_i};

  // Round the Q(2*FracBits) accumulator to Q2.16 and clamp to the output range
  always_comb begin
    round_sum = acc_q + RoundConst;
    r_sh      = round_sum >>> FracBits;
    y_d       = r_sh[DataWidth-1:0];
    sat_d     = 1'b0;
    if (r_sh > MaxPos) begin
      y_d   = {1'b0, {(DataWidth - 1){1'b1}}};
      sat_d = 1'b1;
    end else if (r_sh < MinNeg) begin
      y_d   = {1'b1, {(DataWidth - 1){1'b0}}};
      sat_d = 1'b1;
    end
  end

  // Multiply-accumulate pipeline; valid bits follow the memory read enables
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_valid_q   <= 1'b0;
      prod_valid_q <= 1'b0;
      prod_q       <= '0;
      acc_q        <= '0;
    end else begin
      rd_valid_q   <= ce_q;
      prod_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        prod_q <= h_ext * x_ext;
      end
      if (accept) begin
        acc_q <= '0;
      end else if (prod_valid_q) begin
        acc_q <= acc_q + {{(AccWidth - ProdWidth){prod_q[ProdWidth-1]}}, prod_q};
      end
    end
  end

  // Sequencer: issue N reads, wait for the pipeline to empty, publish the result
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ce_q    <= 1'b0;
      sat_q   <= 1'b0;
      y_q     <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
            ce_q    <= 1'b1;
            addr_q  <= '0;
          end
        end
        ISSUE: begin
          if (addr_q == LastIdx) begin
            ce_q    <= 1'b0;
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (!rd_valid_q && !prod_valid_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            y_q     <= y_d;
            sat_q   <= sat_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign h_ce0_o      = ce_q;
  assign x_ce0_o      = ce_q;
  assign h_address0_o = addr_q;
  assign x_address0_o = addr_q;
  assign y_o          = y_q;
  assign sat_o        = sat_q;

endmodule

// File: tb/tb_mpc_qp_admm_mvmult_row_mac.sv
// tb/tb_mpc_qp_admm_mvmult_row_mac.sv - Self-checking bench for the row dot-product engine
module tb_mpc_qp_admm_mvmult_row_mac;

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  h_address0;
  logic        h_ce0;
  logic [17:0] h_q0;
  logic [4:0]  x_address0;
  logic        x_ce0;
  logic [17:0] x_q0;
  logic [17:0] y;
  logic        sat;

  logic [17:0] h_mem [32];
  logic [17:0] x_mem [32];

  int errors;
  int checks;

  int          ce_cnt;
  int          addr_err;
  int          busy_err;
  int          done_cyc;
  int          done_cnt;
  logic [17:0] cap_y;
  logic        cap_sat;

  mpc_qp_admm_mvmult_row_mac dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .h_address0_o (h_address0),
    .h_ce0_o      (h_ce0),
    .h_q0_i       (h_q0),
    .x_address0_o (x_address0),
    .x_ce0_o      (x_ce0),
    .x_q0_i       (x_q0),
    .y_o          (y),
    .sat_o        (sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM / RAM with one-cycle registered read; output holds when not enabled
  always @(posedge clk) begin
    if (h_ce0) h_q0 <= h_mem[h_address0];
    if (x_ce0) x_q0 <= x_mem[x_address0];
  end

  function automatic void ref_row(output logic [17:0] ey, output logic es);
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < 24; k++) begin
      acc += longint'($signed(h_mem[k])) * longint'($signed(x_mem[k]));
    end
    r = (acc + 64'sd32768) >>> 16;
    if (r > 131071) begin
      ey = 18'h1FFFF; es = 1'b1;
    end else if (r < -131072) begin
      ey = 18'h20000; es = 1'b1;
    end else begin
      ey = r[17:0]; es = 1'b0;
    end
  endfunction

  task automatic clear_mems();
    for (int k = 0; k < 32; k++) begin
      h_mem[k] = 18'h0;
      x_mem[k] = 18'h0;
    end
  endtask

  // Start one row and observe 40 cycles; cycle 0 is the start-sampling cycle
  task automatic run_row(input bit extra_start);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ce_cnt = 0; addr_err = 0; busy_err = 0; done_cyc = -1; done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = extra_start && (c == 5);
      if (h_ce0) begin
        if (h_address0 !== 5'(ce_cnt) || x_address0 !== h_address0 || x_ce0 !== 1'b1) addr_err++;
        ce_cnt++;
      end else if (x_ce0) begin
        addr_err++;
      end
      if (busy !== ((c >= 1) && (c <= 28))) busy_err++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          cap_y = y;
          cap_sat = sat;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, h_ce0, x_ce0, sat} !== 5'b0 || y !== 18'h0 || h_address0 !== 5'h0 || x_address0 !== 5'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b ce=%b%b sat=%b y=%h ha=%h xa=%h, want all zero",
               busy, done, h_ce0, x_ce0, sat, y, h_address0, x_address0);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_vector();
    clear_mems();
    for (int k = 0; k < 24; k++) h_mem[k] = 18'($urandom);
    run_row(1'b0);
    checks++;
    if (done_cyc !== 28 || done_cnt !== 1) begin
      errors++;
      $display("FAIL zero_done_timing: got cycle=%0d count=%0d, want cycle=28 count=1", done_cyc, done_cnt);
    end
    checks++;
    if (cap_y !== 18'h0 || cap_sat !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: got y=%h sat=%b, want y=00000 sat=0", cap_y, cap_sat);
    end
    checks++;
    if (ce_cnt !== 24 || addr_err !== 0) begin
      errors++;
      $display("FAIL zero_addr_seq: got ce_cycles=%0d addr_errors=%0d, want 24 and 0", ce_cnt, addr_err);
    end
    checks++;
    if (busy_err !== 0) begin
      errors++;
      $display("FAIL zero_busy: got %0d busy mismatches, want 0", busy_err);
    end
  endtask

  task automatic load_single_tap();
    clear_mems();
    for (int k = 0; k < 24; k++) x_mem[k] = 18'($urandom);
    h_mem[4] = 18'h0AF12;
    x_mem[4] = 18'h10000;
  endtask

  task automatic test_single_tap();
    load_single_tap();
    run_row(1'b0);
    checks++;
    if (cap_y !== 18'h0AF12 || cap_sat !== 1'b0 || done_cyc !== 28) begin
      errors++;
      $display("FAIL single_tap: got y=%h sat=%b cycle=%0d, want y=0af12 sat=0 cycle=28", cap_y, cap_sat, done_cyc);
    end
  endtask

  task automatic test_signed_mix();
    clear_mems();
    for (int k = 0; k < 24; k++) x_mem[k] = 18'($urandom);
    h_mem[18] = 18'h10000; x_mem[18] = 18'h08000;
    h_mem[22] = 18'h30000; x_mem[22] = 18'h04000;
    run_row(1'b0);
    checks++;
    if (cap_y !== 18'h04000 || cap_sat !== 1'b0) begin
      errors++;
      $display("FAIL signed_mix: got y=%h sat=%b, want y=04000 sat=0", cap_y, cap_sat);
    end
  endtask

  task automatic test_rounding();
    logic [17:0] hv [3];
    logic [17:0] xv [3];
    logic [17:0] ev [3];
    hv[0] = 18'h00001; xv[0] = 18'h08000; ev[0] = 18'h00001;
    hv[1] = 18'h00001; xv[1] = 18'h07FFF; ev[1] = 18'h00000;
    hv[2] = 18'h3FFFF; xv[2] = 18'h08000; ev[2] = 18'h00000;
    for (int i = 0; i < 3; i++) begin
      clear_mems();
      h_mem[0] = hv[i];
      x_mem[0] = xv[i];
      run_row(1'b0);
      checks++;
      if (cap_y !== ev[i] || cap_sat !== 1'b0) begin
        errors++;
        $display("FAIL rounding_%0d: got y=%h sat=%b, want y=%h sat=0", i, cap_y, cap_sat, ev[i]);
      end
    end
  endtask

  task automatic test_saturation();
    clear_mems();
    for (int k = 0; k < 24; k++) begin
      h_mem[k] = 18'h10000;
      x_mem[k] = 18'h10000;
    end
    run_row(1'b0);
    checks++;
    if (cap_y !== 18'h1FFFF || cap_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_positive: got y=%h sat=%b, want y=1ffff sat=1", cap_y, cap_sat);
    end
    for (int k = 0; k < 24; k++) x_mem[k] = 18'h30000;
    run_row(1'b0);
    checks++;
    if (cap_y !== 18'h20000 || cap_sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_negative: got y=%h sat=%b, want y=20000 sat=1", cap_y, cap_sat);
    end
  endtask

  task automatic test_random();
    logic [17:0] ey;
    logic        es;
    for (int i = 0; i < 8; i++) begin
      clear_mems();
      for (int k = 0; k < 24; k++) begin
        if (i < 3) begin
          h_mem[k] = 18'($urandom);
          x_mem[k] = 18'($urandom);
        end else begin
          h_mem[k] = 18'($signed($urandom_range(32768, 0)) - 16384);
          x_mem[k] = 18'($signed($urandom_range(32768, 0)) - 16384);
        end
      end
      ref_row(ey, es);
      run_row(1'b0);
      checks++;
      if (cap_y !== ey || cap_sat !== es || done_cyc !== 28) begin
        errors++;
        $display("FAIL random_%0d: got y=%h sat=%b cycle=%0d, want y=%h sat=%b cycle=28",
                 i, cap_y, cap_sat, done_cyc, ey, es);
      end
    end
  endtask

  task automatic test_start_ignored();
    load_single_tap();
    run_row(1'b1);
    checks++;
    if (done_cnt !== 1 || done_cyc !== 28 || cap_y !== 18'h0AF12) begin
      errors++;
      $display("FAIL start_ignored: got dones=%0d cycle=%0d y=%h, want dones=1 cycle=28 y=0af12",
               done_cnt, done_cyc, cap_y);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    load_single_tap();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || y !== 18'h0 || h_ce0 !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_state: got busy=%b y=%h ce=%b done=%b, want all zero", busy, y, h_ce0, done);
    end
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL reset_abort_no_done: got %0d dones, want 0", dones);
    end
    run_row(1'b0);
    checks++;
    if (cap_y !== 18'h0AF12 || cap_sat !== 1'b0 || done_cyc !== 28) begin
      errors++;
      $display("FAIL reset_restart: got y=%h sat=%b cycle=%0d, want y=0af12 sat=0 cycle=28", cap_y, cap_sat, done_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int d_first;
    int d_second;
    int dones;
    load_single_tap();
    d_first = -1; d_second = -1; dones = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (d_first < 0) d_first = c;
        else if (d_second < 0) d_second = c;
        checks++;
        if (y !== 18'h0AF12) begin
          errors++;
          $display("FAIL b2b_value: got y=%h at cycle %0d, want 0af12", y, c);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (d_first !== 28 || d_second !== 57 || dones !== 2) begin
      errors++;
      $display("FAIL b2b_timing: got first=%0d second=%0d dones=%0d, want 28 57 2", d_first, d_second, dones);
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    start  = 1'b0;
    reset  = 1'b1;
    h_q0   = 18'h0;
    x_q0   = 18'h0;
    clear_mems();
    test_reset();
    test_zero_vector();
    test_single_tap();
    test_signed_mix();
    test_rounding();
    test_saturation();
    test_random();
    test_start_ignored();
    test_signed_mix();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
